// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron scheduler.
// The optional spike counter is enabled with the LIF_SPIKE_CNT_EN macro.
package lif_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StUpdate,
    StDone
  } lif_state_e;

  localparam int unsigned DefNeurons = 4;
  localparam int unsigned DefW       = 8;
  localparam int unsigned DefTau     = 2;
  localparam int unsigned DefThresh  = 4;

  // A single neuron still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lif_event_fifo.sv
// Synchronous FIFO for spike events. The pointers wrap modulo DEPTH, so DEPTH must be
// a power of 2. A push while full is accepted only when a pop happens in the same cycle.
module lif_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [DW-1:0]             data_i,
  input  logic                      pop_i,
  output logic [DW-1:0]             data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic           push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Active-high asynchronous reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Shares one leaky-integrate-and-fire datapath across N_NEURONS neurons and queues
// spike events. Defining LIF_SPIKE_CNT_EN adds the spk_cnt_o total-spike counter.
module lif_neuron_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS  = DefNeurons,
  parameter int unsigned W          = DefW,
  parameter int unsigned TAU        = DefTau,
  parameter int unsigned THRESH     = DefThresh,
  parameter int unsigned REFRAC     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tick_i,
  input  logic [N_NEURONS*W-1:0]           isyn_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [N_NEURONS-1:0]             spk_vec_o,
  output logic                             spk_valid_o,
  input  logic                             spk_ready_i,
  output logic [idx_width(N_NEURONS)-1:0]  spk_id_o,
  output logic                             drop_o,
  output logic                             tick_miss_o
`ifdef LIF_SPIKE_CNT_EN
  ,
  output logic [15:0]                      spk_cnt_o
`endif
);

  localparam int unsigned IdxW = idx_width(N_NEURONS);
  localparam int unsigned RefW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [W:0]      ThreshExt = (W+1)'(THRESH);
  localparam logic [RefW-1:0] RefInit   = RefW'(REFRAC);

  lif_state_e           state_q;
  logic [IdxW-1:0]      idx_q;
  logic [W-1:0]         snap_q [N_NEURONS];
  logic [W-1:0]         v_q    [N_NEURONS];
  logic [RefW-1:0]      refr_q [N_NEURONS];
  logic [N_NEURONS-1:0] shadow_q, shadow_d, spk_vec_q;
  logic                 done_q, drop_q, miss_q;

  logic [W-1:0]         v_cur, isyn_cur, v_sat;
  logic [RefW-1:0]      refr_cur;
  logic [W:0]           sum;
  logic                 in_refr, fire;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [IdxW-1:0]      fifo_head;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  // One neuron update per cycle; W+1 bits catch the overflow before saturating.
  always_comb begin
    v_cur    = v_q[idx_q];
    isyn_cur = snap_q[idx_q];
    refr_cur = refr_q[idx_q];
    sum      = {1'b0, v_cur} - {1'b0, (v_cur >> TAU)} + {1'b0, isyn_cur};
    v_sat    = sum[W] ? '1 : sum[W-1:0];
    in_refr  = (refr_cur != '0);
    fire     = (state_q == StUpdate) && !in_refr && ({1'b0, v_sat} >= ThreshExt);
    shadow_d = shadow_q | ({{(N_NEURONS-1){1'b0}}, fire} << idx_q);
  end

  assign fifo_pop    = spk_valid_o & spk_ready_i;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign spk_vec_o   = spk_vec_q;
  assign spk_valid_o = ~fifo_empty;
  assign spk_id_o    = fifo_empty ? '0 : fifo_head;
  assign drop_o      = drop_q;
  assign tick_miss_o = miss_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      shadow_q  <= '0;
      spk_vec_q <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      miss_q    <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        snap_q[k] <= '0;
        v_q[k]    <= '0;
        refr_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (tick_i && (state_q != StIdle)) miss_q <= 1'b1;
      if (fire && fifo_full && !fifo_pop) drop_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (tick_i) state_q <= StLoad;
        end
        StLoad: begin
          for (int k = 0; k < N_NEURONS; k++) snap_q[k] <= isyn_i[k*W +: W];
          shadow_q <= '0;
          idx_q    <= '0;
          state_q  <= StUpdate;
        end
        StUpdate: begin
          if (in_refr) begin
            refr_q[idx_q] <= refr_cur - RefW'(1);
            v_q[idx_q]    <= '0;
          end else if (fire) begin
            refr_q[idx_q] <= RefInit;
            v_q[idx_q]    <= '0;
          end else begin
            v_q[idx_q]    <= v_sat;
          end
          shadow_q <= shadow_d;
          if (idx_q == IdxW'(N_NEURONS - 1)) begin
            spk_vec_q <= shadow_d;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  lif_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (IdxW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fire),
    .data_i  (idx_q),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

`ifdef LIF_SPIKE_CNT_EN
  logic [15:0] spk_cnt_q;

  // Counts every spike, including ones the full FIFO drops.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      spk_cnt_q <= '0;
    end else if (fire && (spk_cnt_q != 16'hFFFF)) begin
      spk_cnt_q <= spk_cnt_q + 16'd1;
    end
  end

  assign spk_cnt_o = spk_cnt_q;
`endif

endmodule
